key_debounce: RTL
=================

Name: key_debounce

Overview:
- Per-key debouncer between the DE2-115 push-button pins and the key PIO's `in_port` (edge-capture/IRQ stage).
- Synchronises the raw asynchronous active-low KEY inputs and filters contact bounce with a per-channel counter and FSM.
- Drives a clean active-low level to the PIO, which then sees exactly one falling edge per physical press.
- Also emits one-cycle press/release strobes for hardware consumers.

Parameters:
- `NUM_KEYS`, 4, number of independent key channels.
- `DEBOUNCE_CYCLES`, 1000000, cycles the synchronised input must stay stable to be accepted (20 ms at 50 MHz); legal range 2 .. 2^`CNT_W`.
- `CNT_W`, 20, stability counter width; must hold `DEBOUNCE_CYCLES`-1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset.
- `key_in`  in  `NUM_KEYS`  raw board KEY pins, active-low, asynchronous to `clk`.
- `key_out`  out  `NUM_KEYS`  debounced level, active-low (1 = released); connects to PIO `in_port`.
- `press_pulse`  out  `NUM_KEYS`  one-cycle strobe on accepted press (`key_out` bit 1->0).
- `release_pulse`  out  `NUM_KEYS`  one-cycle strobe on accepted release (`key_out` bit 0->1).

Behaviour:
- Clock/reset: clock `clk`; reset `reset_n`, asynchronous, active-low. All state is in the `clk` domain.
- Reset values:
  - `key_out` = all ones.
  - `press_pulse` = 0 and `release_pulse` = 0.
  - Synchroniser flops = all ones.
  - Counters = 0.
  - Every channel FSM = `REL`.
- Synchroniser: per bit, two flops `s1` <= `key_in`, `s2` <= `s1`. Only `s2` feeds the FSM. No combinational path from `key_in` to any output.
- Channel FSM, independent per bit i. All outputs are registered.
  - `REL` (`key_out[i]`=1):
    - `s2`=0 -> `PRESS_PEND`, cnt<=0.
    - else stay.
  - `PRESS_PEND` (`key_out[i]`=1):
    - `s2`=1 -> `REL`, cnt<=0 (bounce rejected, no pulse).
    - `s2`=0 and cnt==`DEBOUNCE_CYCLES`-1 -> `PRESSED`, `key_out[i]`<=0, `press_pulse[i]`<=1 for one cycle.
    - else cnt<=cnt+1.
  - `PRESSED` (`key_out[i]`=0):
    - `s2`=1 -> `REL_PEND`, cnt<=0.
    - else stay.
  - `REL_PEND` (`key_out[i]`=0):
    - `s2`=0 -> `PRESSED`, cnt<=0.
    - `s2`=1 and cnt==`DEBOUNCE_CYCLES`-1 -> `REL`, `key_out[i]`<=1, `release_pulse[i]`<=1 for one cycle.
    - else cnt<=cnt+1.
- Latency: if `key_in[i]` is stable from before edge E0 (the `s1` capture edge), `key_out[i]` and the pulse update at edge E0+`DEBOUNCE_CYCLES`+2. The pulse is high for exactly that one cycle.
- Filtering:
  - Any excursion of `s2` shorter than `DEBOUNCE_CYCLES` cycles produces no change on `key_out` and no pulse.
  - Each bounce restarts the count from 0.
- Guarantees to the PIO: `key_out[i]` high and low periods are each ≥ `DEBOUNCE_CYCLES` cycles. There is at most one falling edge per accepted press.
- Held key: `key_out` stays 0 indefinitely. No auto-repeat, no further pulses.
- Counter: saturating is not required. It never exceeds `DEBOUNCE_CYCLES`-1 because the FSM leaves the pending state at that value. Counter arithmetic is unsigned, `CNT_W` bits.
- Simultaneous events: channels are fully independent. Several pulse bits may be high in the same cycle.
- Reset mid-operation: asynchronous return to reset values in all states. No pulse is generated on reset entry or exit. After reset release with a key held low, a normal press is accepted after the full latency.

Test Plan (bench uses `DEBOUNCE_CYCLES`=8, `CNT_W`=4, `NUM_KEYS`=4):
- Clean press: reset, then `key_in`=4'b1110 held. Required: `key_out`=4'b1110 at edge E0+10; `press_pulse`=4'b0001 for exactly one cycle at that edge; `release_pulse` stays 0.
- Bounce reject: `key_in[1]` toggles 0/1 every 3 cycles for 40 cycles, then returns to 1. Required: `key_out` stays 4'b1111 and no pulses throughout.
- Bounce then settle: `key_in[2]` gets 5 bounces of 3 cycles, then held 0. Required: `key_out[2]`=0 exactly 10 cycles after the final `s1` capture of 0; a single `press_pulse[2]`.
- Release: from `PRESSED`, `key_in[0]`->1 with a 4-cycle low glitch at cycle 3. Required: `release_pulse[0]` once; `key_out[0]`=1 at 10 cycles after the post-glitch stable edge.
- Simultaneous: `key_in` 4'b1111->4'b0000 on one edge. Required: `press_pulse`=4'b1111 in a single cycle; `key_out`=4'b0000.
- Reset mid-count: assert `reset_n`=0 while ch3 is in `PRESS_PEND` with cnt=5. Required: outputs immediately all ones/zero pulses; after release with `key_in[3]` still 0, `press_pulse[3]` at E0+10 and no earlier.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button debouncer: a two-flop synchroniser per key feeds an independent
// counter/FSM channel that emits a clean active-low level plus press/release strobes.

module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_sync,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse
);
    typedef enum logic [1:0] {REL, PRESS_PEND, PRESSED, REL_PEND} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= REL;
            cnt           <= '0;
            key_out       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                REL: begin
                    if (!key_sync) begin
                        state <= PRESS_PEND;
                        cnt   <= '0;
                    end
                end
                PRESS_PEND: begin
                    // any return to released restarts the whole qualification
                    if (key_sync) begin
                        state <= REL;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        key_out     <= 1'b0;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (key_sync) begin
                        state <= REL_PEND;
                        cnt   <= '0;
                    end
                end
                REL_PEND: begin
                    if (!key_sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= REL;
                        cnt           <= '0;
                        key_out       <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= REL;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);
    logic [NUM_KEYS-1:0] s1, s2;

    // synchroniser resets to "released" so reset exit never looks like a press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .key_sync     (s2[i]),
            .key_out      (key_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end
endmodule
